mips_mem_arbiter: RTL and testbench

- Shares one unified instruction/data memory between the fetch stage (I port) and the memory-access stage (D port) of the MIPS core.
- Each request is sequenced through a req/rdy handshake with a variable-latency memory.
- Arbitrates between I and D with data priority, plus an anti-starvation limit for fetch.
- Drives a stall to the core while any request is outstanding.
- Detects memory timeouts.

---
 rtl/mips_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one unified memory between the fetch stage (I port)
// and the memory-access stage (D port) of the MIPS core.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           fetch read request, held until if_ack
//   if_rdata/if_ack          fetched word and one-cycle completion pulse
//   ma_req/ma_we/ma_addr/ma_wdata  data request, held until ma_ack
//   ma_rdata/ma_ack          read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, stable until mem_rdy
//   mem_rdata/mem_rdy        memory read data and completion
//   stall                    combinational core hold while a request is pending
//   err                      sticky memory-timeout flag
//
// Data has priority; after MAX_WAIT consecutive fetch losses the fetch wins.
// An access with no mem_rdy for TIMEOUT busy cycles is terminated with err.
module mips_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        ma_req,
    input  logic        ma_we,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    output logic [31:0] ma_rdata,
    output logic        ma_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = $clog2(MAX_WAIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            if_ack_d, ma_ack_d, mem_req_d, mem_we_d, err_d;
    logic [DW-1:0]   if_rdata_d, ma_rdata_d, mem_addr_d, mem_wdata_d;

    logic            finish;
    logic [DW-1:0]   fin_data;

    // Core is held while either port has a request that is not being acked now.
    assign stall = (if_req & ~if_ack) | (ma_req & ~ma_ack);

    // Arbitration, transaction sequencing and timeout.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        if_ack_d    = 1'b0;
        ma_ack_d    = 1'b0;
        if_rdata_d  = if_rdata;
        ma_rdata_d  = ma_rdata;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        err_d       = err;
        finish      = 1'b0;
        fin_data    = '0;

        case (state_q)
            IDLE: begin
                // The ack cycle is a bubble: the acked requester still shows
                // req here and drops it only after seeing the ack.
                if (!(if_ack || ma_ack)) begin
                    if (ma_req && (!if_req || starve_q != SW'(MAX_WAIT))) begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ma_we;
                        mem_addr_d  = ma_addr;
                        mem_wdata_d = ma_wdata;
                        tmo_d       = '0;
                        if (if_req && starve_q != SW'(MAX_WAIT)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (if_req) begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        tmo_d       = '0;
                        starve_d    = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_rdy) begin
                    finish   = 1'b1;
                    fin_data = mem_rdata;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without mem_rdy.
                    finish   = 1'b1;
                    fin_data = '1;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion (normal or timed out): release memory and ack the owner.
        if (finish) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (state_q == BUSY_I) begin
                if_ack_d   = 1'b1;
                if_rdata_d = fin_data;
            end else begin
                ma_ack_d = 1'b1;
                if (!mem_we) begin
                    ma_rdata_d = fin_data;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            tmo_q     <= '0;
            if_ack    <= 1'b0;
            ma_ack    <= 1'b0;
            if_rdata  <= '0;
            ma_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            if_ack    <= if_ack_d;
            ma_ack    <= ma_ack_d;
            if_rdata  <= if_rdata_d;
            ma_rdata  <= ma_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios, a transaction-level model
// checked against the DUT every cycle, and hand-computed literal pins.
module tb_mips_mem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ma_req = 1'b0;
    logic        ma_we = 1'b0;
    logic [31:0] ma_addr = '0;
    logic [31:0] ma_wdata = '0;
    logic [31:0] ma_rdata;
    logic        ma_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        stall;
    logic        err;

    mips_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata), .ma_ack(ma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .stall(stall), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_loss  = 0;   // consecutive fetch losses
    int          m_wait  = 0;   // busy cycles without mem_rdy
    logic        m_if_ack = 0, m_ma_ack = 0, m_mem_req = 0, m_mem_we = 0, m_err = 0;
    logic [31:0] m_if_rdata = '0, m_ma_rdata = '0, m_mem_addr = '0, m_mem_wdata = '0;
    logic        m_blocked, m_fin;
    logic [31:0] m_data;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_owner = 0; m_loss = 0; m_wait = 0;
            m_if_ack = 0; m_ma_ack = 0; m_mem_req = 0; m_mem_we = 0; m_err = 0;
            m_if_rdata = '0; m_ma_rdata = '0; m_mem_addr = '0; m_mem_wdata = '0;
        end else begin
            m_blocked = m_if_ack | m_ma_ack;
            m_if_ack  = 0;
            m_ma_ack  = 0;
            m_fin     = 0;
            m_data    = '0;
            if (m_owner == 0) begin
                if (!m_blocked) begin
                    if (ma_req && (!if_req || m_loss < MAX_WAIT)) begin
                        m_owner = 2;
                        if (if_req) m_loss = (m_loss + 1 > MAX_WAIT) ? MAX_WAIT : m_loss + 1;
                        m_mem_req = 1; m_mem_we = ma_we;
                        m_mem_addr = ma_addr; m_mem_wdata = ma_wdata;
                        m_wait = 0;
                    end else if (if_req) begin
                        m_owner = 1;
                        m_loss = 0;
                        m_mem_req = 1; m_mem_we = 0;
                        m_mem_addr = if_addr; m_mem_wdata = '0;
                        m_wait = 0;
                    end
                end
            end else if (mem_rdy) begin
                m_fin = 1; m_data = mem_rdata;
            end else begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin
                    m_fin = 1; m_data = 32'hFFFF_FFFF; m_err = 1;
                end
            end
            if (m_fin) begin
                if (m_owner == 1) begin
                    m_if_ack = 1; m_if_rdata = m_data;
                end else begin
                    m_ma_ack = 1;
                    if (!m_mem_we) m_ma_rdata = m_data;
                end
                m_owner = 0; m_mem_req = 0; m_mem_we = 0;
            end
        end
    end

    // Every out-of-reset cycle: DUT against model, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            chk("if_ack",    32'(if_ack),  32'(m_if_ack));
            chk("ma_ack",    32'(ma_ack),  32'(m_ma_ack));
            chk("if_rdata",  if_rdata,     m_if_rdata);
            chk("ma_rdata",  ma_rdata,     m_ma_rdata);
            chk("mem_req",   32'(mem_req), 32'(m_mem_req));
            chk("mem_we",    32'(mem_we),  32'(m_mem_we));
            chk("mem_addr",  mem_addr,     m_mem_addr);
            chk("mem_wdata", mem_wdata,    m_mem_wdata);
            chk("err",       32'(err),     32'(m_err));
            chk("stall",     32'(stall),   32'((if_req & ~m_if_ack) | (ma_req & ~m_ma_ack)));
        end
    end

    // ---------------- stimulus helpers ----------------
    int          lat = 1;         // mem_rdy in the lat-th mem_req cycle, 0 = never
    int          r_cnt = 0;
    logic [31:0] rsp_data = '0;
    bit          stray = 0;       // drive mem_rdy while memory is idle
    bit          hold_i = 0, hold_d = 0;
    int          n_if_ack = 0, n_ma_ack = 0, n_memreq = 0;
    int          ack_log[$];

    // One clock; then the requesters and memory react to the new outputs.
    task automatic step();
        @(posedge CLK);
        #1;
        if (if_ack) begin n_if_ack++; ack_log.push_back(1); if (!hold_i) if_req = 0; end
        if (ma_ack) begin n_ma_ack++; ack_log.push_back(2); if (!hold_d) ma_req = 0; end
        if (mem_req) begin
            n_memreq++;
            r_cnt++;
            mem_rdy = (lat != 0) && (r_cnt == lat);
        end else begin
            r_cnt = 0;
            mem_rdy = stray;
        end
        mem_rdata = rsp_data;
    endtask

    task automatic wait_ack(input int which, input int budget, output int at);
        at = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((which == 1 && if_ack) || (which == 2 && ma_ack)) begin
                at = i;
                break;
            end
        end
        if (at < 0) chk("ack_wait_budget", 32'(budget), 32'(0));
    endtask

    int at;
    int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        #1 RST = 0;
        step(); step();
        RST = 1;
        // Reset state.
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ma_rdata", ma_rdata, 32'd0);

        // 1: reset during BUSY_D with no mem_rdy.
        lat = 0; ma_we = 0; ma_addr = 32'h1001_0000; ma_req = 1;
        step(); step(); step();
        chk("t1_busy_mem_req", 32'(mem_req), 32'd1);
        #2;
        RST = 0; ma_req = 0;
        #1;
        chk("t1_async_mem_req", 32'(mem_req), 32'd0);
        chk("t1_async_outs", {ma_ack, if_ack, mem_we, err, stall, 27'd0}, 32'd0);
        chk("t1_async_addr", mem_addr, 32'd0);
        step(); step();
        RST = 1; lat = 1; n_ma_ack = 0;
        repeat (20) step();
        chk("t1_no_ack_after_reset", 32'(n_ma_ack), 32'd0);

        // 2: fetch with mem_rdy in the 3rd mem_req cycle.
        lat = 3; rsp_data = 32'h8C22_0004; n_memreq = 0;
        if_addr = 32'h0040_0000; if_req = 1;
        #1;
        chk("t2_stall_cycle0", 32'(stall), 32'd1);
        wait_ack(1, 30, at);
        chk("t2_ack_cycle", 32'(at), 32'd4);
        chk("t2_if_rdata", if_rdata, 32'h8C22_0004);
        chk("t2_memreq_cycles", 32'(n_memreq), 32'd3);
        step();

        // 3: data read to seed ma_rdata, then a single-cycle write.
        lat = 2; rsp_data = 32'h1234_5678;
        ma_we = 0; ma_addr = 32'h1001_0004; ma_req = 1;
        wait_ack(2, 30, at);
        chk("t3_read_ack_cycle", 32'(at), 32'd3);
        chk("t3_read_data", ma_rdata, 32'h1234_5678);
        step();
        lat = 1; rsp_data = 32'h5555_AAAA;
        ma_we = 1; ma_addr = 32'h1001_0008; ma_wdata = 32'hDEAD_BEEF; ma_req = 1;
        step();
        chk("t3_mem_we", 32'(mem_we), 32'd1);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_addr", mem_addr, 32'h1001_0008);
        step();
        chk("t3_ma_ack_cycle2", 32'(ma_ack), 32'd1);
        chk("t3_mem_we_off", 32'(mem_we), 32'd0);
        chk("t3_rdata_kept", ma_rdata, 32'h1234_5678);
        step();
        ma_we = 0;

        // 4: both ports requesting continuously.
        ack_log.delete();
        lat = 1; rsp_data = 32'h0000_0042;
        hold_i = 1; hold_d = 1;
        if_addr = 32'h0040_0010; ma_addr = 32'h1001_0010;
        if_req = 1; ma_req = 1;
        for (int i = 0; i < 200 && ack_log.size() < 10; i++) step();
        hold_i = 0; hold_d = 0; if_req = 0; ma_req = 0;
        chk("t4_ack_count", 32'(ack_log.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < ack_log.size(); i++)
            chk($sformatf("t4_grant_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
        repeat (6) step();

        // 5: data read never answered -> timeout.
        lat = 0; ma_we = 0; ma_addr = 32'h1001_0020; ma_req = 1;
        wait_ack(2, 40, at);
        chk("t5_ack_cycle", 32'(at), 32'd17);
        chk("t5_rdata_ones", ma_rdata, 32'hFFFF_FFFF);
        chk("t5_err", 32'(err), 32'd1);
        step();
        lat = 2; rsp_data = 32'h2402_0001;
        if_addr = 32'h0040_0004; if_req = 1;
        wait_ack(1, 30, at);
        chk("t5_next_ack_cycle", 32'(at), 32'd3);
        chk("t5_next_rdata", if_rdata, 32'h2402_0001);
        chk("t5_err_sticky", 32'(err), 32'd1);
        step();

        // 6: fetch request dropped right after the grant; stray mem_rdy after.
        lat = 3; rsp_data = 32'h0000_0020;
        if_addr = 32'h0040_0008; if_req = 1;
        step();
        if_req = 0; n_if_ack = 0;
        wait_ack(1, 30, at);
        chk("t6_ack_cycle", 32'(at), 32'd3);
        chk("t6_if_rdata", if_rdata, 32'h0000_0020);
        stray = 1; n_memreq = 0;
        repeat (6) step();
        stray = 0;
        chk("t6_no_second_req", 32'(n_memreq), 32'd0);
        chk("t6_single_ack", 32'(n_if_ack), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
